// File: rtl/mem_access_unit_if.sv
// MEM-stage bus bundle: EX/MEM request, registered load response
// and the word-wide DataMem port.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [13:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    output stall, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    input  stall, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end for a word-wide DataMem.
// Sub-word stores run as a two-cycle read-modify-write.
module mem_access_unit #(
  parameter int MEM_DEPTH = 100,
  parameter bit WORD_ADDR = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  mem_access_unit_if.slave bus
);

  typedef enum logic {IDLE, RMW} state_t;

  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  state_t      state;
  state_t      state_nx;
  logic [31:0] wbuf;
  logic [13:0] widx;

  logic [13:0] idx;
  logic [1:0]  lane;
  logic        err;
  logic        go;
  logic        is_sw;
  logic        is_sub;
  logic [31:0] shifted;
  logic [31:0] ld_data;
  logic [31:0] mask;
  logic [31:0] ins;
  logic [31:0] merged;
  logic        unused_bits;

  assign lane = bus.req_addr[1:0];
  assign idx  = WORD_ADDR ? bus.req_addr[15:2]
                          : {bus.req_addr[13:2], 2'b00};
  assign unused_bits = ^bus.req_addr[31:14];

  // classify the request: alignment, funct3 legality and index range
  always_comb begin
    err = 1'b0;
    case (bus.req_funct3)
      3'b000:  err = 1'b0;
      3'b001:  err = lane[0];
      3'b010:  err = |lane;
      3'b100:  err = bus.req_we;
      3'b101:  err = bus.req_we | lane[0];
      default: err = 1'b1;
    endcase
    if ({18'b0, idx} >= DEPTH)
      err = 1'b1;
  end

  assign go     = bus.req_valid & ~err;
  assign is_sw  = bus.req_we & (bus.req_funct3 == 3'b010);
  assign is_sub = bus.req_we & (bus.req_funct3 != 3'b010);

  assign shifted = bus.mem_RD >> {lane, 3'b000};

  // pick the load lane and extend it
  always_comb begin
    ld_data = shifted;
    case (bus.req_funct3)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'b0, shifted[7:0]};
      3'b101:  ld_data = {16'b0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  // merge sub-word store data into the old word
  always_comb begin
    if (bus.req_funct3 == 3'b000) begin
      mask = 32'h0000_00ff << {lane, 3'b000};
      ins  = {4{bus.req_wdata[7:0]}};
    end else begin
      mask = 32'h0000_ffff << {lane[1], 4'b0000};
      ins  = {2{bus.req_wdata[15:0]}};
    end
    merged = (bus.mem_RD & ~mask) | (ins & mask);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state: sub-word store enters RMW for one cycle
  always_comb begin
    state_nx = IDLE;
    unique case (state)
      IDLE: if (go && is_sub) state_nx = RMW;
      RMW:  state_nx = IDLE;
    endcase
  end

  // DataMem port and stall
  always_comb begin
    bus.mem_A  = idx;
    bus.mem_WD = bus.req_wdata;
    bus.mem_WE = 1'b0;
    bus.stall  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.mem_WE = go & is_sw;
        bus.stall  = go & is_sub;
      end
      RMW: begin
        bus.mem_A  = widx;
        bus.mem_WD = wbuf;
        bus.mem_WE = 1'b1;
      end
    endcase
  end

  // response registers and RMW write buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      wbuf          <= '0;
      widx          <= '0;
    end else if (state == RMW || !bus.req_valid) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else if (err) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b1;
    end else if (!bus.req_we) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_rdata <= ld_data;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      if (is_sub) begin
        wbuf <= merged;
        widx <= idx;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural DataMem.
// Inputs change on negedge; outputs are sampled #1 after edges.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  logic [31:0] last = '0;
  logic [31:0] dmem [0:99];

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_DEPTH(100), .WORD_ADDR(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_RD = (bus.mem_A < 14'd100) ? dmem[bus.mem_A] : 32'h0;

  always @(posedge clk)
    if (bus.mem_WE && bus.mem_A < 14'd100)
      dmem[bus.mem_A] <= bus.mem_WD;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid  = v;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    drive(1'b1, 1'b0, f3, a, 32'h0);
    #1;
    chk({tag, ".stall"}, 32'(bus.stall), 32'h0);
    chk({tag, ".we"}, 32'(bus.mem_WE), 32'h0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk({tag, ".valid"}, 32'(bus.rsp_valid), 32'h1);
    chk({tag, ".rdata"}, bus.rsp_rdata, exp);
    chk({tag, ".err"}, 32'(bus.rsp_err), 32'h0);
    last = exp;
  endtask

  task automatic do_sub(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp, input int idx);
    @(negedge clk);
    drive(1'b1, 1'b1, f3, a, wd);
    #1;
    chk({tag, ".stall1"}, 32'(bus.stall), 32'h1);
    chk({tag, ".we1"}, 32'(bus.mem_WE), 32'h0);
    @(posedge clk);
    #1;
    chk({tag, ".stall2"}, 32'(bus.stall), 32'h0);
    chk({tag, ".we2"}, 32'(bus.mem_WE), 32'h1);
    chk({tag, ".wd"}, bus.mem_WD, exp);
    chk({tag, ".a"}, 32'(bus.mem_A), 32'(idx));
    chk({tag, ".valid"}, 32'(bus.rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk({tag, ".mem"}, dmem[idx], exp);
  endtask

  task automatic do_err(input string tag, input logic we,
                        input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    drive(1'b1, we, f3, a, 32'hdead_beef);
    #1;
    chk({tag, ".stall"}, 32'(bus.stall), 32'h0);
    chk({tag, ".we"}, 32'(bus.mem_WE), 32'h0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk({tag, ".err"}, 32'(bus.rsp_err), 32'h1);
    chk({tag, ".valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, ".rdata"}, bus.rsp_rdata, last);
    @(posedge clk);
    #1;
    chk({tag, ".pulse"}, 32'(bus.rsp_err), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 100; i++) dmem[i] = 32'h0;
    dmem[0] = 32'h9f5d_4a6e;
    dmem[4] = 32'h0000_000e;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #12;
    chk("rst.valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst.rdata", bus.rsp_rdata, 32'h0);
    chk("rst.err", 32'(bus.rsp_err), 32'h0);
    chk("rst.we", 32'(bus.mem_WE), 32'h0);
    chk("rst.stall", 32'(bus.stall), 32'h0);
    rst_n = 1'b1;

    do_load("lb0", 3'b000, 32'd0, 32'h0000_006e);
    do_load("lb3", 3'b000, 32'd3, 32'hffff_ff9f);
    do_load("lhu2", 3'b101, 32'd2, 32'h0000_9f5d);
    do_load("lh2", 3'b001, 32'd2, 32'hffff_9f5d);
    do_load("lw4", 3'b010, 32'd4, 32'h0000_000e);
    do_load("lbu3", 3'b100, 32'd3, 32'h0000_009f);

    do_sub("sb1", 3'b000, 32'd1, 32'h0000_00ab, 32'h9f5d_ab6e, 0);
    do_load("lw0", 3'b010, 32'd0, 32'h9f5d_ab6e);

    do_sub("sh6", 3'b001, 32'd6, 32'h1234_c0de, 32'hc0de_000e, 4);
    do_load("lh6", 3'b001, 32'd6, 32'hffff_c0de);

    @(negedge clk);
    drive(1'b1, 1'b1, 3'b010, 32'd8, 32'h1234_5678);
    #1;
    chk("sw8.stall", 32'(bus.stall), 32'h0);
    chk("sw8.we", 32'(bus.mem_WE), 32'h1);
    chk("sw8.wd", bus.mem_WD, 32'h1234_5678);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("sw8.valid", 32'(bus.rsp_valid), 32'h0);
    chk("sw8.mem", dmem[8], 32'h1234_5678);
    do_load("lw8", 3'b010, 32'd8, 32'h1234_5678);

    do_err("lw2", 1'b0, 3'b010, 32'd2);
    do_err("sh1", 1'b1, 3'b001, 32'd1);
    chk("sh1.mem", dmem[0], 32'h9f5d_ab6e);
    do_err("f011", 1'b0, 3'b011, 32'd0);
    do_err("range", 1'b0, 3'b010, 32'd400);
    do_err("sbu", 1'b1, 3'b100, 32'd0);
    chk("sbu.mem", dmem[0], 32'h9f5d_ab6e);

    @(negedge clk);
    drive(1'b1, 1'b1, 3'b001, 32'd0, 32'h0000_beef);
    #1;
    chk("rrst.stall", 32'(bus.stall), 32'h1);
    @(posedge clk);
    #1;
    chk("rrst.we1", 32'(bus.mem_WE), 32'h1);
    chk("rrst.wd", bus.mem_WD, 32'h9f5d_beef);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("rrst.we0", 32'(bus.mem_WE), 32'h0);
    chk("rrst.valid", 32'(bus.rsp_valid), 32'h0);
    chk("rrst.rdata", bus.rsp_rdata, 32'h0);
    chk("rrst.err", 32'(bus.rsp_err), 32'h0);
    chk("rrst.stall2", 32'(bus.stall), 32'h0);
    @(posedge clk);
    #1;
    chk("rrst.mem", dmem[0], 32'h9f5d_ab6e);
    rst_n = 1'b1;
    do_load("lwfin", 3'b010, 32'd0, 32'h9f5d_ab6e);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
